// File: rtl/fetch_unit.sv
// Byte-serial instruction fetch: assembles big-endian 32-bit words plus an
// optional 64-bit immediate and hands them to decode over valid/ready.
module fetch_unit #(
  parameter int unsigned           ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter logic [15:0]           IMM_OP_MIN = 16'h0100
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [7:0]            imem_rdata,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_instr,
  output logic                  out_has_imm,
  output logic [63:0]           out_imm,
  output logic [ADDR_WIDTH-1:0] out_pc
);
  typedef enum logic [1:0] {S_INSN, S_IMM, S_HOLD} state_e;

  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK  = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};
  localparam logic [ADDR_WIDTH-1:0] PC_ONE      = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] RESET_PC_AL = RESET_PC & ALIGN_MASK;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d, insn_pc_q, insn_pc_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [31:0]           instr_q, instr_d;
  // Only 7 immediate bytes are buffered; the 8th goes straight to out_imm.
  logic [55:0]           imm_q, imm_d;
  logic                  out_valid_q, out_valid_d, out_has_imm_q, out_has_imm_d;
  logic [31:0]           out_instr_q, out_instr_d;
  logic [63:0]           out_imm_q, out_imm_d;
  logic [ADDR_WIDTH-1:0] out_pc_q, out_pc_d;

  logic [ADDR_WIDTH-1:0] pc_inc;
  logic [31:0]           instr_shift;
  logic [63:0]           imm_shift;

  assign pc_inc      = pc_q + PC_ONE;
  assign instr_shift = {instr_q[23:0], imem_rdata};
  assign imm_shift   = {imm_q, imem_rdata};

  assign imem_addr   = pc_q;
  assign out_valid   = out_valid_q;
  assign out_instr   = out_instr_q;
  assign out_has_imm = out_has_imm_q;
  assign out_imm     = out_imm_q;
  assign out_pc      = out_pc_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    insn_pc_d     = insn_pc_q;
    cnt_d         = cnt_q;
    instr_d       = instr_q;
    imm_d         = imm_q;
    out_valid_d   = out_valid_q;
    out_instr_d   = out_instr_q;
    out_has_imm_d = out_has_imm_q;
    out_imm_d     = out_imm_q;
    out_pc_d      = out_pc_q;
    if (redirect_valid) begin
      // A held bundle with out_ready=1 on this edge is already consumed by decode.
      pc_d          = redirect_pc & ALIGN_MASK;
      insn_pc_d     = redirect_pc & ALIGN_MASK;
      state_d       = S_INSN;
      cnt_d         = 3'd0;
      imm_d         = '0;
      out_valid_d   = 1'b0;
      out_has_imm_d = 1'b0;
      out_imm_d     = '0;
    end else begin
      unique case (state_q)
        S_INSN: begin
          instr_d = instr_shift;
          pc_d    = pc_inc;
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd3) begin
            cnt_d = 3'd0;
            if (instr_shift[31:16] >= IMM_OP_MIN) begin
              state_d = S_IMM;
            end else begin
              state_d       = S_HOLD;
              out_valid_d   = 1'b1;
              out_instr_d   = instr_shift;
              out_has_imm_d = 1'b0;
              out_imm_d     = '0;
              out_pc_d      = insn_pc_q;
            end
          end
        end
        S_IMM: begin
          imm_d = imm_shift[55:0];
          pc_d  = pc_inc;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            state_d       = S_HOLD;
            cnt_d         = 3'd0;
            out_valid_d   = 1'b1;
            out_instr_d   = instr_q;
            out_has_imm_d = 1'b1;
            out_imm_d     = imm_shift;
            out_pc_d      = insn_pc_q;
          end
        end
        S_HOLD: begin
          // Handshake edge doubles as byte 0 of the next instruction: no bubble.
          if (out_ready) begin
            state_d     = S_INSN;
            out_valid_d = 1'b0;
            instr_d     = instr_shift;
            pc_d        = pc_inc;
            insn_pc_d   = pc_q;
            cnt_d       = 3'd1;
          end
        end
        default: state_d = S_INSN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_INSN;
      pc_q          <= RESET_PC_AL;
      insn_pc_q     <= RESET_PC_AL;
      cnt_q         <= 3'd0;
      instr_q       <= '0;
      imm_q         <= '0;
      out_valid_q   <= 1'b0;
      out_instr_q   <= '0;
      out_has_imm_q <= 1'b0;
      out_imm_q     <= '0;
      out_pc_q      <= RESET_PC_AL;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      insn_pc_q     <= insn_pc_d;
      cnt_q         <= cnt_d;
      instr_q       <= instr_d;
      imm_q         <= imm_d;
      out_valid_q   <= out_valid_d;
      out_instr_q   <= out_instr_d;
      out_has_imm_q <= out_has_imm_d;
      out_imm_q     <= out_imm_d;
      out_pc_q      <= out_pc_d;
    end
  end
endmodule
